// File: rtl/dfr_phase_sequencer.sv
// Reservoir run sequencer: INIT / TRAIN / TEST phases, sample fetch and per-sample step handshakes.
// Optional ack watchdog is built when DFR_SEQ_TIMEOUT_EN is defined; otherwise error is tied low.
module dfr_phase_sequencer #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_init_samples,
  input  logic [CNT_W-1:0] num_train_samples,
  input  logic [CNT_W-1:0] num_test_samples,
  input  logic [CNT_W-1:0] num_steps_per_sample,
  output logic             sample_req,
  input  logic             sample_ack,
  output logic [CNT_W-1:0] sample_idx,
  output logic             step_req,
  input  logic             step_ack,
  output logic [CNT_W-1:0] step_idx,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FETCH, S_STEP, S_DONE} state_t;

  localparam logic [1:0] PH_INIT = 2'd0;
  localparam logic [1:0] PH_TEST = 2'd2;
  localparam logic [1:0] PH_IDLE = 2'd3;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] sample_idx_q, sample_idx_d;
  logic [CNT_W-1:0] step_idx_q, step_idx_d;
  logic [CNT_W-1:0] sh_init_q, sh_train_q, sh_test_q, sh_steps_q;
  logic [CNT_W-1:0] cur_samples;
  logic             load_cfg;
  logic             end_of_sample;
  logic             timeout_hit;

  // Shadowed sample count of the phase currently being run
  always_comb begin
    cur_samples = sh_test_q;
    unique case (phase_q)
      2'd0:    cur_samples = sh_init_q;
      2'd1:    cur_samples = sh_train_q;
      default: cur_samples = sh_test_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= PH_IDLE;
      sample_idx_q <= '0;
      step_idx_q   <= '0;
      sh_init_q    <= '0;
      sh_train_q   <= '0;
      sh_test_q    <= '0;
      sh_steps_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sample_idx_q <= sample_idx_d;
      step_idx_q   <= step_idx_d;
      if (load_cfg) begin
        sh_init_q  <= num_init_samples;
        sh_train_q <= num_train_samples;
        sh_test_q  <= num_test_samples;
        sh_steps_q <= num_steps_per_sample;
      end
    end
  end

  // Next state; compares against count-1 only happen once the count is known nonzero
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    sample_idx_d  = sample_idx_q;
    step_idx_d    = step_idx_q;
    load_cfg      = 1'b0;
    end_of_sample = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          phase_d  = PH_INIT;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cur_samples == '0) begin
          if (phase_q == PH_TEST) state_d = S_DONE;
          else                    phase_d = phase_q + 2'd1;
        end else begin
          sample_idx_d = '0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        if (sample_ack) begin
          step_idx_d = '0;
          if (sh_steps_q != '0) state_d = S_STEP;
          else                  end_of_sample = 1'b1;
        end
      end
      S_STEP: begin
        if (step_ack) begin
          if (step_idx_q == sh_steps_q - CNT_W'(1)) end_of_sample = 1'b1;
          else                                      step_idx_d = step_idx_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        phase_d = PH_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (end_of_sample) begin
      if (sample_idx_q != cur_samples - CNT_W'(1)) begin
        sample_idx_d = sample_idx_q + CNT_W'(1);
        state_d      = S_FETCH;
      end else if (phase_q == PH_TEST) begin
        state_d = S_DONE;
      end else begin
        phase_d = phase_q + 2'd1;
        state_d = S_SETUP;
      end
    end
    if (timeout_hit) state_d = S_DONE;
  end

  // State-decoded handshake and status outputs
  always_comb begin
    sample_req = 1'b0;
    step_req   = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_FETCH: sample_req = 1'b1;
      S_STEP:  step_req   = 1'b1;
      S_DONE:  done       = 1'b1;
      default: ;
    endcase
  end

  assign phase      = phase_q;
  assign sample_idx = sample_idx_q;
  assign step_idx   = step_idx_q;

`ifdef DFR_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            error_q;
  logic            waiting;

  assign waiting     = (sample_req && !sample_ack) || (step_req && !step_ack);
  assign timeout_hit = waiting && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign error       = error_q;

  // Watchdog: counts unacknowledged req cycles, cleared by every handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (waiting && !timeout_hit) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                         to_cnt_q <= '0;
      if (timeout_hit) error_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign error              = 1'b0;
`endif

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Self-checking bench for dfr_phase_sequencer: directed and randomized runs against a handshake-list model.
module tb_dfr_phase_sequencer;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_init_samples = '0;
  logic [CNT_W-1:0] num_train_samples = '0;
  logic [CNT_W-1:0] num_test_samples = '0;
  logic [CNT_W-1:0] num_steps_per_sample = '0;
  logic             sample_req;
  logic             sample_ack = 1'b0;
  logic [CNT_W-1:0] sample_idx;
  logic             step_req;
  logic             step_ack = 1'b0;
  logic [CNT_W-1:0] step_idx;
  logic [1:0]       phase;
  logic             busy;
  logic             done;
  logic             error;

  int n_checks = 0;
  int n_fails  = 0;

  dfr_phase_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_init_samples(num_init_samples), .num_train_samples(num_train_samples),
    .num_test_samples(num_test_samples), .num_steps_per_sample(num_steps_per_sample),
    .sample_req(sample_req), .sample_ack(sample_ack), .sample_idx(sample_idx),
    .step_req(step_req), .step_ack(step_ack), .step_idx(step_idx),
    .phase(phase), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Responder configuration and monitor accumulators
  int  s_delay = 0, t_delay = 0, s_wait = 0, t_wait = 0;
  bit  spur_en = 1'b0, hold_step = 1'b0;
  int  busy_cycles = 0, done_cnt = 0, done_at = 0, both_cnt = 0, unstable = 0;
  int  sreq_cycles = 0, treq_cycles = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [1:0]  ph_q[$];
  logic             s_pend = 1'b0, t_pend = 1'b0;
  logic [CNT_W-1:0] p_sidx = '0, p_tidx = '0;
  logic [1:0]       p_ph = 2'd0;

  function automatic logic [63:0] enc(input logic k, input logic [1:0] ph,
                                      input logic [31:0] si, input logic [31:0] ti);
    return {k, ph, 5'd0, si[27:0], ti[27:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ack responder (ack after a fixed number of wait cycles) plus passive monitor
  always @(negedge clk) begin
    if (sample_req) begin
      sample_ack = (s_wait >= s_delay);
      s_wait     = sample_ack ? 0 : s_wait + 1;
    end else begin
      sample_ack = spur_en && ($urandom_range(0, 1) == 1);
      s_wait     = 0;
    end
    if (step_req && !hold_step) begin
      step_ack = (t_wait >= t_delay);
      t_wait   = step_ack ? 0 : t_wait + 1;
    end else begin
      step_ack = spur_en && !step_req && ($urandom_range(0, 1) == 1);
      t_wait   = 0;
    end
    if (busy) busy_cycles++;
    if (done) begin
      done_cnt++;
      done_at = busy_cycles;
    end
    if (busy && (ph_q.size() == 0 || ph_q[$] != phase)) ph_q.push_back(phase);
    if (sample_req && step_req) both_cnt++;
    if (sample_req) sreq_cycles++;
    if (step_req) treq_cycles++;
    if (s_pend && (!sample_req || sample_idx != p_sidx || phase != p_ph)) unstable++;
    if (t_pend && (!step_req || step_idx != p_tidx || sample_idx != p_sidx || phase != p_ph))
      unstable++;
    if (sample_req && sample_ack) obs_q.push_back(enc(1'b0, phase, sample_idx, 32'd0));
    if (step_req && step_ack) obs_q.push_back(enc(1'b1, phase, sample_idx, step_idx));
    s_pend = sample_req && !sample_ack && !rst;
    t_pend = step_req && !step_ack && !rst;
    p_sidx = sample_idx;
    p_tidx = step_idx;
    p_ph   = phase;
  end

  task automatic clear_mon();
    busy_cycles = 0; done_cnt = 0; done_at = 0; both_cnt = 0; unstable = 0;
    sreq_cycles = 0; treq_cycles = 0;
    obs_q.delete(); ph_q.delete();
  endtask

  // Pulse start and wait (bounded) for the run to finish; optionally disturb it mid-run
  task automatic launch(input int budget, input bit disturb);
    clear_mon();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      if (disturb && k == 3) begin
        start                = 1'b1;
        num_init_samples     = 32'($urandom_range(0, 9));
        num_train_samples    = 32'($urandom_range(0, 9));
        num_test_samples     = 32'($urandom_range(0, 9));
        num_steps_per_sample = 32'($urandom_range(0, 9));
      end else begin
        start = 1'b0;
      end
      tick(1);
    end
    start = 1'b0;
    chk("run_completes", 64'(done_cnt > 0), 64'd1);
    tick(2);
  endtask

  task automatic run(input int ni, input int nt, input int nte, input int ns,
                     input int sd, input int td, input bit disturb);
    int cnt[3];
    int tot, nsamp, nmin;
    cnt[0] = ni; cnt[1] = nt; cnt[2] = nte;
    num_init_samples     = 32'(ni);
    num_train_samples    = 32'(nt);
    num_test_samples     = 32'(nte);
    num_steps_per_sample = 32'(ns);
    s_delay = sd;
    t_delay = td;
    exp_q.delete();
    tot   = 1;
    nsamp = 0;
    for (int p = 0; p < 3; p++) begin
      tot   += 1 + cnt[p] * (1 + sd + ns * (1 + td));
      nsamp += cnt[p];
      for (int i = 0; i < cnt[p]; i++) begin
        exp_q.push_back(enc(1'b0, 2'(p), 32'(i), 32'd0));
        for (int j = 0; j < ns; j++) exp_q.push_back(enc(1'b1, 2'(p), 32'(i), 32'(j)));
      end
    end
    launch(tot + 50, disturb);
    chk("busy_cycles", 64'(busy_cycles), 64'(tot));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("done_cycle", 64'(done_at), 64'(tot));
    chk("sample_req_cycles", 64'(sreq_cycles), 64'(nsamp * (1 + sd)));
    chk("step_req_cycles", 64'(treq_cycles), 64'(nsamp * ns * (1 + td)));
    chk("req_overlap", 64'(both_cnt), 64'd0);
    chk("req_stable", 64'(unstable), 64'd0);
    chk("hs_count", 64'(obs_q.size()), 64'(exp_q.size()));
    nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) chk("hs_item", obs_q[i], exp_q[i]);
    chk("phase_seq_len", 64'(ph_q.size()), 64'd3);
    for (int i = 0; i < ph_q.size() && i < 3; i++) chk("phase_seq", 64'(ph_q[i]), 64'(i));
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_phase", 64'(phase), 64'd3);
    chk("end_error", 64'(error), 64'd0);
  endtask

  initial begin
    int found, noisy;
    tick(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sample_req", 64'(sample_req), 64'd0);
    chk("rst_step_req", 64'(step_req), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_phase", 64'(phase), 64'd3);
    chk("rst_sample_idx", 64'(sample_idx), 64'd0);
    chk("rst_step_idx", 64'(step_idx), 64'd0);
    rst = 1'b0;
    tick(1);

    run(1, 2, 1, 3, 0, 0, 1'b0);
    run(0, 0, 2, 0, 0, 0, 1'b0);
    run(1, 2, 1, 3, 5, 2, 1'b0);
    spur_en = 1'b1;
    run(2, 1, 2, 2, 1, 0, 1'b1);

    // Abort from STEP with step_idx=1
    num_init_samples = 32'd2; num_train_samples = 32'd0; num_test_samples = 32'd0;
    num_steps_per_sample = 32'd3; s_delay = 0; t_delay = 0;
    start = 1'b1; tick(1); start = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (step_req && step_idx == 32'd1) found = 1;
      else tick(1);
    end
    chk("abort_reached", 64'(found), 64'd1);
    rst = 1'b1;
    tick(1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sample_req", 64'(sample_req), 64'd0);
    chk("abort_step_req", 64'(step_req), 64'd0);
    chk("abort_phase", 64'(phase), 64'd3);
    chk("abort_step_idx", 64'(step_idx), 64'd0);
    rst = 1'b0;
    noisy = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (sample_req || step_req || busy) noisy++;
    end
    chk("abort_quiet", 64'(noisy), 64'd0);
    run(1, 1, 1, 2, 0, 1, 1'b0);

    // Maximum step count is legal: steps keep advancing without wrap
    num_init_samples = 32'd1; num_train_samples = 32'd0; num_test_samples = 32'd0;
    num_steps_per_sample = 32'hFFFF_FFFF; s_delay = 0; t_delay = 0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(9);
    chk("maxcnt_step_req", 64'(step_req), 64'd1);
    chk("maxcnt_step_idx", 64'(step_idx), 64'd7);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);

    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
          1'b0);

`ifdef DFR_SEQ_TIMEOUT_EN
    spur_en = 1'b0; hold_step = 1'b1;
    num_init_samples = 32'd1; num_train_samples = 32'd0; num_test_samples = 32'd0;
    num_steps_per_sample = 32'd2; s_delay = 0; t_delay = 0;
    launch(100, 1'b0);
    chk("wd_step_req_cycles", 64'(treq_cycles), 64'd16);
    chk("wd_done_count", 64'(done_cnt), 64'd1);
    chk("wd_error", 64'(error), 64'd1);
    chk("wd_busy", 64'(busy), 64'd0);
    tick(5);
    chk("wd_error_sticky", 64'(error), 64'd1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("wd_error_cleared", 64'(error), 64'd0);
    hold_step = 1'b0;
    tick(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
